// File: rtl/seq_add_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and
// counter sizing.
package seq_add_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Chunk counter width; a single-chunk build still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/adder.sv
// N-bit ripple adder with carry in/out; the shared datapath element of the
// chunked sequencer.
module adder #(
    parameter int unsigned N = 4
) (
    output logic [N-1:0] sum,
    output logic         carry_out,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         carry_in
);

    assign {carry_out, sum} = {1'b0, in1} + {1'b0, in2} + {{N{1'b0}}, carry_in};

endmodule

// File: rtl/seq_chunk_add_ctrl.sv
// Wide N*K-bit adder built by running one N-bit adder over K cycles, LSB chunk
// first, with the inter-chunk carry held in a register.
module seq_chunk_add_ctrl
    import seq_add_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*K-1:0] in1,
    input  logic [N*K-1:0] in2,
    input  logic           carry_in,
    output logic           busy,
    output logic           done,
    output logic [N*K-1:0] sum,
    output logic           carry_out
);

    localparam int unsigned W  = N * K;
    localparam int unsigned CW = cnt_w(K);

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    psum_q;
    logic [W-1:0]    psum_next;
    logic            c_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    add_sum;
    logic            add_co;
    logic            last_chunk;

    adder #(
        .N(N)
    ) u_adder (
        .sum      (add_sum),
        .carry_out(add_co),
        .in1      (a_q[N-1:0]),
        .in2      (b_q[N-1:0]),
        .carry_in (c_q)
    );

    // New chunk enters at the top; after K shifts chunk 0 sits at the bottom.
    if (K == 1) begin : g_psum_single
        assign psum_next = add_sum;
    end else begin : g_psum_shift
        assign psum_next = {add_sum, psum_q[W-1:N]};
    end

    assign last_chunk = (cnt_q == CW'(K - 1));
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            psum_q    <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q     <= in1;
                        b_q     <= in2;
                        c_q     <= carry_in;
                        cnt_q   <= '0;
                        psum_q  <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    psum_q <= psum_next;
                    c_q    <= add_co;
                    a_q    <= a_q >> N;
                    b_q    <= b_q >> N;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_chunk) begin
                        sum       <= psum_next;
                        carry_out <= add_co;
                        state_q   <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
